mac_tx_framer: RTL
==================

# mac_tx_framer

Parametrised Ethernet MAC transmit framer. It takes a byte stream of payload from the upper layer under a ready/valid handshake and emits a complete frame toward the MII, one byte per clock: preamble, SFD, destination MAC, source MAC, EtherType, payload, zero padding to the minimum payload length, FCS, then an enforced inter-packet gap. Compared with the first-generation transmitter, it adds parametrised addressing and gap length, padding, CRC-32 FCS, maximum-length enforcement and underrun signalling.

## Interface
Parameters:
- DEST_MAC, 48'hFFFF_FFFF_FFFF, destination address; the most significant byte is sent first.
- SRC_MAC, 48'h02_00_00_00_00_01, source address; the most significant byte is sent first.
- ETHER_TYPE, 16'h0800, EtherType; the high byte is sent first.
- MIN_PAYLOAD, 46, payload bytes after padding; legal range 1..MAX_PAYLOAD.
- MAX_PAYLOAD, 1500, maximum number of payload bytes accepted per frame.
- IPG_BYTES, 12, idle byte-times after each frame; minimum 1.

Ports:
- in_clk  input  1  byte clock; all logic is on the rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_txen  input  1  upper layer has a payload byte valid (and requests a frame while in IDLE).
- in_txd  input  8  payload byte.
- in_last  input  1  qualifies in_txd as the final payload byte.
- out_tx_ready  output  1  the framer accepts in_txd on this edge.
- out_txen  output  1  out_txd carries a frame byte.
- out_txd  output  8  frame byte to the MII.
- out_underrun  output  1  one-cycle pulse: payload was starved mid-frame.
- out_oversize  output  1  one-cycle pulse: the frame was truncated at MAX_PAYLOAD.

## Operation
- States: IDLE, PREAMBLE (7 bytes of 0x55), SFD (0xD5), DEST (6 bytes), SRC (6 bytes), TYPE (2 bytes), PAYLOAD, PAD, FCS (4 bytes), IPG (IPG_BYTES cycles).
- Per-state byte index counter: 4 bits. Payload counter: $clog2(MAX_PAYLOAD+1) bits; it saturates and never wraps.
- IDLE -> PREAMBLE when in_txen=1. No byte is consumed on this transition.
- out_tx_ready=1 only while in PAYLOAD. A byte is accepted when in_txen && out_tx_ready; the payload counter then increments.
- Accepted byte with in_last=1:
  - If count+1 < MIN_PAYLOAD, go to PAD and emit 0x00 until the count reaches MIN_PAYLOAD.
  - Otherwise go to FCS.
- Accepted byte that makes count == MAX_PAYLOAD without in_last: treat it as the last byte, pulse out_oversize, go to FCS. Padding never applies in this case.
- in_txen=0 while in PAYLOAD is an underrun: pulse out_underrun, go to FCS, and send the bitwise complement of the correct FCS so the receiver discards the frame. No padding is inserted.
- FCS: IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Covers DEST through PAD.
  - The final value is complemented and sent least significant byte first.
- IPG: out_txen=0 and out_txd=0x00 for IPG_BYTES cycles, then IDLE. in_txen is ignored during IPG.
- Simultaneous in_last and MAX reached: normal termination; out_oversize is not pulsed.

## Timing
- All outputs are registered.
- out_txd and out_txen lag the state by one cycle.
- out_tx_ready is decoded from the registered state.
- Request edge k in IDLE -> first 0x55 on out_txd/out_txen after edge k+1.
- The SFD appears 7 cycles after the first preamble byte.
- A payload byte accepted at edge n appears on out_txd after edge n+1.
- out_txen is continuous from the first preamble byte to the last FCS byte; there are no gaps.
- Frame-to-frame: the next preamble starts no earlier than IPG_BYTES+1 cycles after the last FCS byte.
- Reset values (applied immediately on in_rst, including mid-frame):
  - out_txen=0, out_txd=8'h00, out_tx_ready=0, out_underrun=0, out_oversize=0.
  - State=IDLE, counters=0, CRC=0xFFFFFFFF.
  - A frame cut by reset is not resumed.

## Configuration
- MAC_TX_FCS_EN defined: FCS state and CRC logic are present, as specified above.
- MAC_TX_FCS_EN undefined:
  - No CRC logic.
  - PAYLOAD/PAD go directly to IPG; frames are 4 bytes shorter.
  - Underrun still pulses out_underrun and ends the frame at once.

## Test plan
- Reset, then 46-byte payload 0x00..0x2D with in_last on the 46th byte -> 72 consecutive out_txen cycles: 7×0x55, 0xD5, FF×6, 02 00 00 00 00 01, 08 00, the payload, then an FCS equal to the software CRC-32 model.
- 1-byte payload 0xAB -> 45 bytes of 0x00 padding; the frame is still 72 bytes; the FCS covers the padding.
- in_txen held high with no in_last -> exactly 1500 bytes accepted, out_oversize pulses once, out_tx_ready falls, 4 FCS bytes follow.
- in_txen dropped after 10 payload bytes -> out_underrun pulses; FCS bytes equal ~(correct FCS); no padding.
- Back-to-back requests -> exactly 12 cycles with out_txen=0 between frames.
- in_rst asserted mid-payload -> outputs reach reset values asynchronously; the next request produces a clean frame starting with 0x55.
- Repeat the first scenario with MAC_TX_FCS_EN undefined -> 68 bytes.

Source files
------------

// File: rtl/mac_tx_framer.sv
// -----------------------------------------------------------------------------
// mac_tx_framer
//
// Ethernet MAC transmit framer. Accepts a payload byte stream under a
// ready/valid handshake and emits a complete frame toward the MII, one byte
// per clock:
//   preamble (7 x 0x55), SFD (0xD5), destination MAC, source MAC, EtherType,
//   payload, zero padding up to MIN_PAYLOAD, FCS, then an inter-packet gap.
//
// Optional feature macro: MAC_TX_FCS_EN
//   defined   -> CRC-32 FCS is generated and appended (4 bytes, LSB first).
//   undefined -> no CRC logic; the body is followed directly by the gap.
//
// Ports:
//   in_clk        byte clock, rising edge
//   in_rst        asynchronous active-high reset
//   in_txen       payload byte valid / frame request while idle
//   in_txd[7:0]   payload byte
//   in_last       in_txd is the final payload byte
//   out_tx_ready  payload byte is accepted on this edge (state is PAYLOAD)
//   out_txen      out_txd carries a frame byte
//   out_txd[7:0]  frame byte to the MII
//   out_underrun  one-cycle pulse: payload starved mid-frame
//   out_oversize  one-cycle pulse: frame truncated at MAX_PAYLOAD
// -----------------------------------------------------------------------------
module mac_tx_framer #(
   parameter logic [47:0] DEST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHER_TYPE  = 16'h0800,
   parameter int          MIN_PAYLOAD = 46,
   parameter int          MAX_PAYLOAD = 1500,
   parameter int          IPG_BYTES   = 12
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       in_txen,
   input  logic [7:0] in_txd,
   input  logic       in_last,
   output logic       out_tx_ready,
   output logic       out_txen,
   output logic [7:0] out_txd,
   output logic       out_underrun,
   output logic       out_oversize
);

   localparam int CW = $clog2(MAX_PAYLOAD + 1);
   // The gap counter runs over the IPG state only; the IDLE cycle that
   // samples the next request supplies the final idle byte-time.
   localparam int GW = (IPG_BYTES > 2) ? $clog2(IPG_BYTES - 1) : 1;

   localparam logic [CW:0]   MIN_C    = (CW+1)'(MIN_PAYLOAD);
   localparam logic [CW:0]   MAX_C    = (CW+1)'(MAX_PAYLOAD);
   localparam logic [CW:0]   ONE_C    = (CW+1)'(1);
   localparam logic [GW-1:0] GAP_LAST = GW'((IPG_BYTES > 1) ? IPG_BYTES - 2 : 0);

   typedef enum logic [3:0] {
      S_IDLE, S_PREAMBLE, S_SFD, S_DEST, S_SRC, S_TYPE,
      S_PAYLOAD, S_PAD, S_FCS, S_IPG
   } state_t;

   localparam state_t S_AFTER_FCS  = (IPG_BYTES > 1) ? S_IPG : S_IDLE;
`ifdef MAC_TX_FCS_EN
   localparam state_t S_AFTER_BODY = S_FCS;
`else
   localparam state_t S_AFTER_BODY = S_AFTER_FCS;
`endif

   state_t        state, state_n;
   logic [3:0]    idx, idx_n;
   logic [CW-1:0] pay_cnt, cnt_n;
   logic [CW:0]   cnt_p1;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [47:0]   dest_sh, src_sh;
   logic [7:0]    txd_p0;
   logic          vld_p0, urun_p0, ovr_p0;

`ifdef MAC_TX_FCS_EN
   logic [31:0]   crc, crc_n, fcs_word, fcs_sh;
   logic          fcs_bad, bad_n, crc_upd;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // An underrun frame carries the complement of the correct FCS, i.e. the
   // raw running CRC, so the receiver is guaranteed to drop it.
   assign fcs_word = fcs_bad ? crc : ~crc;
   assign fcs_sh   = fcs_word >> {idx, 3'b000};
`endif

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= CW'(MAX_PAYLOAD)) ? v : v + CW'(1);
   endfunction

   assign cnt_p1       = {1'b0, pay_cnt} + ONE_C;
   assign dest_sh      = DEST_MAC << {idx, 3'b000};
   assign src_sh       = SRC_MAC << {idx, 3'b000};
   assign out_tx_ready = (state == S_PAYLOAD);

   // ---- stage p0: next state and the byte this state emits ----
   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = pay_cnt;
      gap_n   = gap_cnt;
      txd_p0  = 8'h00;
      vld_p0  = 1'b0;
      urun_p0 = 1'b0;
      ovr_p0  = 1'b0;
`ifdef MAC_TX_FCS_EN
      crc_n   = crc;
      bad_n   = fcs_bad;
      crc_upd = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            idx_n = 4'd0;
            cnt_n = '0;
            gap_n = '0;
`ifdef MAC_TX_FCS_EN
            crc_n = 32'hFFFF_FFFF;
            bad_n = 1'b0;
`endif
            if (in_txen) state_n = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            txd_p0 = 8'h55;
            vld_p0 = 1'b1;
            if (idx == 4'd6) begin
               state_n = S_SFD;
               idx_n   = 4'd0;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         S_SFD: begin
            txd_p0  = 8'hD5;
            vld_p0  = 1'b1;
            state_n = S_DEST;
            idx_n   = 4'd0;
         end
         S_DEST: begin
            txd_p0 = dest_sh[47:40];
            vld_p0 = 1'b1;
`ifdef MAC_TX_FCS_EN
            crc_upd = 1'b1;
`endif
            if (idx == 4'd5) begin
               state_n = S_SRC;
               idx_n   = 4'd0;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         S_SRC: begin
            txd_p0 = src_sh[47:40];
            vld_p0 = 1'b1;
`ifdef MAC_TX_FCS_EN
            crc_upd = 1'b1;
`endif
            if (idx == 4'd5) begin
               state_n = S_TYPE;
               idx_n   = 4'd0;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         S_TYPE: begin
            txd_p0 = (idx == 4'd0) ? ETHER_TYPE[15:8] : ETHER_TYPE[7:0];
            vld_p0 = 1'b1;
`ifdef MAC_TX_FCS_EN
            crc_upd = 1'b1;
`endif
            if (idx == 4'd1) begin
               state_n = S_PAYLOAD;
               idx_n   = 4'd0;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         S_PAYLOAD: begin
            if (in_txen) begin
               txd_p0 = in_txd;
               vld_p0 = 1'b1;
               cnt_n  = sat_inc(pay_cnt);
`ifdef MAC_TX_FCS_EN
               crc_upd = 1'b1;
`endif
               if (in_last) begin
                  state_n = (cnt_p1 < MIN_C) ? S_PAD : S_AFTER_BODY;
                  idx_n   = 4'd0;
                  gap_n   = '0;
               end else if (cnt_p1 == MAX_C) begin
                  ovr_p0  = 1'b1;
                  state_n = S_AFTER_BODY;
                  idx_n   = 4'd0;
                  gap_n   = '0;
               end
            end else begin
               urun_p0 = 1'b1;
               gap_n   = '0;
`ifdef MAC_TX_FCS_EN
               // Emit the first (corrupted) FCS byte in this very cycle so
               // out_txen stays continuous through the aborted frame.
               txd_p0  = crc[7:0];
               vld_p0  = 1'b1;
               bad_n   = 1'b1;
               state_n = S_FCS;
               idx_n   = 4'd1;
`else
               state_n = S_AFTER_FCS;
               idx_n   = 4'd0;
`endif
            end
         end
         S_PAD: begin
            txd_p0 = 8'h00;
            vld_p0 = 1'b1;
            cnt_n  = sat_inc(pay_cnt);
`ifdef MAC_TX_FCS_EN
            crc_upd = 1'b1;
`endif
            if (cnt_p1 >= MIN_C) begin
               state_n = S_AFTER_BODY;
               idx_n   = 4'd0;
               gap_n   = '0;
            end
         end
         S_FCS: begin
`ifdef MAC_TX_FCS_EN
            txd_p0 = fcs_sh[7:0];
            vld_p0 = 1'b1;
`endif
            gap_n = '0;
            if (idx == 4'd3) begin
               state_n = S_AFTER_FCS;
               idx_n   = 4'd0;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         S_IPG: begin
            gap_n = gap_cnt + GW'(1);
            if (gap_cnt == GAP_LAST) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
`ifdef MAC_TX_FCS_EN
      if (crc_upd) crc_n = crc_step(crc, txd_p0);
`endif
   end

   // ---- stage p1: registered state and MII outputs ----
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state        <= S_IDLE;
         idx          <= 4'd0;
         pay_cnt      <= '0;
         gap_cnt      <= '0;
         out_txen     <= 1'b0;
         out_txd      <= 8'h00;
         out_underrun <= 1'b0;
         out_oversize <= 1'b0;
`ifdef MAC_TX_FCS_EN
         crc          <= 32'hFFFF_FFFF;
         fcs_bad      <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         pay_cnt      <= cnt_n;
         gap_cnt      <= gap_n;
         out_txen     <= vld_p0;
         out_txd      <= txd_p0;
         out_underrun <= urun_p0;
         out_oversize <= ovr_p0;
`ifdef MAC_TX_FCS_EN
         crc          <= crc_n;
         fcs_bad      <= bad_n;
`endif
      end
   end

endmodule
